// File: rtl/mod_sysinfo_pkg.sv
// Shared register map, CTRL bit positions and the address decoder
// for the system-information peripheral.
package mod_sysinfo_pkg;

    localparam logic [7:0] OFF_CPUID  = 8'h00;
    localparam logic [7:0] OFF_FREQ   = 8'h04;
    localparam logic [7:0] OFF_CYC_LO = 8'h08;
    localparam logic [7:0] OFF_CYC_HI = 8'h0C;
    localparam logic [7:0] OFF_MS     = 8'h10;
    localparam logic [7:0] OFF_CTRL   = 8'h14;
    localparam logic [7:0] OFF_NSCR   = 8'h18;
    localparam logic [7:0] OFF_SCR0   = 8'h20;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam int unsigned MAX_SCRATCH = 8;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_CPUID,
        SEL_FREQ,
        SEL_CYC_LO,
        SEL_CYC_HI,
        SEL_MS,
        SEL_CTRL,
        SEL_NSCR,
        SEL_SCR
    } reg_sel_e;

    // Takes the word address (byte address bits 31:2); anything above 0xFF is unmapped.
    function automatic reg_sel_e decode_sel(input logic [29:0] waddr, input int unsigned nscr);
        logic [7:0] off;
        off = {waddr[5:0], 2'b00};
        decode_sel = SEL_NONE;
        if (waddr[29:6] == 24'd0) begin
            case (off)
                OFF_CPUID:  decode_sel = SEL_CPUID;
                OFF_FREQ:   decode_sel = SEL_FREQ;
                OFF_CYC_LO: decode_sel = SEL_CYC_LO;
                OFF_CYC_HI: decode_sel = SEL_CYC_HI;
                OFF_MS:     decode_sel = SEL_MS;
                OFF_CTRL:   decode_sel = SEL_CTRL;
                OFF_NSCR:   decode_sel = SEL_NSCR;
                default: begin
                    if (off[7:5] == OFF_SCR0[7:5] && 32'(off[4:2]) < nscr)
                        decode_sel = SEL_SCR;
                end
            endcase
        end
    endfunction

endpackage

// File: rtl/mod_sysinfo_tick.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 while enabled and pulses
// tick for one cycle on the edge where it wraps.
module mod_sysinfo_tick #(
    parameter int unsigned TICK_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mod_sysinfo.sv
// System-information peripheral on the PLP data bus: IDs, 64-bit cycle
// counter with snapshot read, millisecond counter and scratch registers.
module mod_sysinfo
    import mod_sysinfo_pkg::*;
#(
    parameter logic [31:0] CPU_ID      = 32'h00000302,
    parameter logic [31:0] BOARD_FREQ  = 32'h017d7840,
    parameter int unsigned TICK_DIV    = BOARD_FREQ / 1000,
    parameter int unsigned NUM_SCRATCH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ie,
    input  logic        de,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [1:0]  drw,
    input  logic [31:0] din,
    output logic [31:0] iout,
    output logic [31:0] dout
);

    reg_sel_e    sel;
    logic [2:0]  scr_idx;
    logic        wr_en, rd_en, ctrl_wr, clr, tick;
    logic        en_q, en_d;
    logic [63:0] cyc_q, cyc_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] ms_q, ms_d;
    logic [31:0] scr_q [MAX_SCRATCH];
    logic        unused_ok;

    assign sel       = decode_sel(daddr[31:2], NUM_SCRATCH);
    assign scr_idx   = daddr[4:2];
    assign wr_en     = de & drw[0];
    assign rd_en     = de & drw[1];
    assign ctrl_wr   = wr_en && (sel == SEL_CTRL);
    assign clr       = ctrl_wr && din[CTRL_CLR_BIT];
    assign iout      = '0;
    assign unused_ok = ^{ie, iaddr, daddr[1:0]};

    mod_sysinfo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en_q),
        .clr  (clr),
        .tick (tick)
    );

    // CLR outranks counting and the CYC_LO snapshot; snapshot takes the pre-edge high word.
    always_comb begin
        en_d   = ctrl_wr ? din[CTRL_EN_BIT] : en_q;
        cyc_d  = cyc_q;
        snap_d = snap_q;
        ms_d   = ms_q;
        if (clr) begin
            cyc_d  = '0;
            snap_d = '0;
            ms_d   = '0;
        end else begin
            if (en_q) cyc_d = cyc_q + 64'd1;
            if (tick) ms_d = ms_q + 32'd1;
            if (rd_en && sel == SEL_CYC_LO) snap_d = cyc_q[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q   <= 1'b1;
            cyc_q  <= '0;
            snap_q <= '0;
            ms_q   <= '0;
        end else begin
            en_q   <= en_d;
            cyc_q  <= cyc_d;
            snap_q <= snap_d;
            ms_q   <= ms_d;
        end
    end

    // NOTE: the scratch bank is software-visible state that must read 0 after reset, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scr_q <= '{default: '0};
        end else if (wr_en && sel == SEL_SCR) begin
            scr_q[scr_idx] <= din;
        end
    end

    always_comb begin
        dout = '0;
        case (sel)
            SEL_CPUID:  dout = CPU_ID;
            SEL_FREQ:   dout = BOARD_FREQ;
            SEL_CYC_LO: dout = cyc_q[31:0];
            SEL_CYC_HI: dout = snap_q;
            SEL_MS:     dout = ms_q;
            SEL_CTRL:   dout = {31'd0, en_q};
            SEL_NSCR:   dout = 32'(NUM_SCRATCH);
            SEL_SCR:    dout = scr_q[scr_idx];
            default:    dout = '0;
        endcase
    end

endmodule

// File: tb/tb_mod_sysinfo.sv
// Directed bench for mod_sysinfo with a 4-clock millisecond prescaler.
module tb_mod_sysinfo;

    logic        clk = 1'b0;
    logic        rst;
    logic        ie, de;
    logic [31:0] iaddr, daddr, din;
    logic [1:0]  drw;
    logic [31:0] iout, dout;

    int pass_cnt = 0;
    int total_cnt = 0;

    mod_sysinfo #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .ie    (ie),
        .de    (de),
        .iaddr (iaddr),
        .daddr (daddr),
        .drw   (drw),
        .din   (din),
        .iout  (iout),
        .dout  (dout)
    );

    always #10 clk = ~clk;

    // Combinational peek without a read strobe.
    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        de = 1'b0; drw = 2'b00; daddr = a;
        #1 v = dout;
    endtask

    // Called in the low phase; the write lands on the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        daddr = a; din = d; drw = 2'b01; de = 1'b1;
        @(negedge clk);
        de = 1'b0; drw = 2'b00;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rd(32'h00, v); total_cnt++;
        if (v !== 32'h00000302) $display("FAIL rst_cpuid: got %h expected %h", v, 32'h00000302); else pass_cnt++;
        rd(32'h04, v); total_cnt++;
        if (v !== 32'h017d7840) $display("FAIL rst_freq: got %h expected %h", v, 32'h017d7840); else pass_cnt++;
        rd(32'h18, v); total_cnt++;
        if (v !== 32'h4) $display("FAIL rst_nscr: got %h expected %h", v, 32'h4); else pass_cnt++;
        rd(32'h14, v); total_cnt++;
        if (v !== 32'h1) $display("FAIL rst_ctrl: got %h expected %h", v, 32'h1); else pass_cnt++;
        rd(32'h08, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL rst_cyclo: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h0C, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL rst_cychi: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h20, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL rst_scr0: got %h expected %h", v, 32'h0); else pass_cnt++;
        total_cnt++;
        if (iout !== 32'h0) $display("FAIL rst_iout: got %h expected %h", iout, 32'h0); else pass_cnt++;
    endtask

    task automatic test_ms;
        logic [31:0] v;
        logic [31:0] exp_ms;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_ms = (k == 4) ? 32'd1 : 32'd0;
            rd(32'h10, v); total_cnt++;
            if (v !== exp_ms) $display("FAIL ms_edge%0d: got %h expected %h", k, v, exp_ms); else pass_cnt++;
        end
        repeat (8) @(negedge clk);
        rd(32'h10, v); total_cnt++;
        if (v !== 32'd3) $display("FAIL ms_12edges: got %h expected %h", v, 32'd3); else pass_cnt++;
        rd(32'h08, v); total_cnt++;
        if (v !== 32'd12) $display("FAIL cyc_12edges: got %h expected %h", v, 32'd12); else pass_cnt++;
    endtask

    task automatic test_en_freeze;
        logic [31:0] v;
        wr(32'h14, 32'h0);
        repeat (20) @(negedge clk);
        rd(32'h10, v); total_cnt++;
        if (v !== 32'd3) $display("FAIL frz_ms: got %h expected %h", v, 32'd3); else pass_cnt++;
        rd(32'h08, v); total_cnt++;
        if (v !== 32'd13) $display("FAIL frz_cyc: got %h expected %h", v, 32'd13); else pass_cnt++;
        rd(32'h14, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL frz_ctrl: got %h expected %h", v, 32'h0); else pass_cnt++;
        wr(32'h14, 32'h1);
        rd(32'h14, v); total_cnt++;
        if (v !== 32'h1) $display("FAIL en_ctrl: got %h expected %h", v, 32'h1); else pass_cnt++;
        rd(32'h08, v); total_cnt++;
        if (v !== 32'd13) $display("FAIL en_cyc_hold: got %h expected %h", v, 32'd13); else pass_cnt++;
        repeat (3) @(negedge clk);
        rd(32'h10, v); total_cnt++;
        if (v !== 32'd4) $display("FAIL en_ms_resume: got %h expected %h", v, 32'd4); else pass_cnt++;
        rd(32'h08, v); total_cnt++;
        if (v !== 32'd16) $display("FAIL en_cyc_resume: got %h expected %h", v, 32'd16); else pass_cnt++;
    endtask

    task automatic test_scratch;
        logic [31:0] v;
        wr(32'h24, 32'hDEADBEEF);
        rd(32'h24, v); total_cnt++;
        if (v !== 32'hDEADBEEF) $display("FAIL scr1: got %h expected %h", v, 32'hDEADBEEF); else pass_cnt++;
        rd(32'h27, v); total_cnt++;
        if (v !== 32'hDEADBEEF) $display("FAIL scr1_byteoff: got %h expected %h", v, 32'hDEADBEEF); else pass_cnt++;
        rd(32'h20, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL scr0_untouched: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h30, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL scr4_unmapped: got %h expected %h", v, 32'h0); else pass_cnt++;
        wr(32'h2C, 32'h0BADF00D);
        rd(32'h2C, v); total_cnt++;
        if (v !== 32'h0BADF00D) $display("FAIL scr3: got %h expected %h", v, 32'h0BADF00D); else pass_cnt++;
        wr(32'h00, 32'h12345678);
        rd(32'h00, v); total_cnt++;
        if (v !== 32'h00000302) $display("FAIL ro_cpuid: got %h expected %h", v, 32'h00000302); else pass_cnt++;
        wr(32'h30, 32'hAAAA5555);
        rd(32'h30, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL wr_scr4: got %h expected %h", v, 32'h0); else pass_cnt++;
        wr(32'h120, 32'h5A5A5A5A);
        rd(32'h120, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL hi_addr_rd: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h20, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL hi_addr_alias: got %h expected %h", v, 32'h0); else pass_cnt++;
        wr(32'h0C, 32'hFFFFFFFF);
        rd(32'h0C, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL ro_cychi: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h1C, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL hole_1c: got %h expected %h", v, 32'h0); else pass_cnt++;
    endtask

    task automatic test_carry;
        logic [31:0] v;
        @(negedge clk);
        dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
        daddr = 32'h08; drw = 2'b10; de = 1'b1;
        #1 v = dout; total_cnt++;
        if (v !== 32'hFFFFFFFF) $display("FAIL carry_lo: got %h expected %h", v, 32'hFFFFFFFF); else pass_cnt++;
        @(negedge clk);
        rd(32'h0C, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL carry_hi: got %h expected %h", v, 32'h0); else pass_cnt++;
        @(negedge clk);
        daddr = 32'h08; drw = 2'b10; de = 1'b1;
        #1 v = dout; total_cnt++;
        if (v !== 32'h1) $display("FAIL pair_lo: got %h expected %h", v, 32'h1); else pass_cnt++;
        @(negedge clk);
        rd(32'h0C, v); total_cnt++;
        if (v !== 32'h1) $display("FAIL pair_hi: got %h expected %h", v, 32'h1); else pass_cnt++;
    endtask

    task automatic test_clr;
        logic [31:0] v;
        daddr = 32'h14; din = 32'h3; drw = 2'b11; de = 1'b1;
        @(negedge clk);
        de = 1'b0; drw = 2'b00;
        rd(32'h08, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL clr_cyclo: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h0C, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL clr_snap: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h10, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL clr_ms: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h14, v); total_cnt++;
        if (v !== 32'h1) $display("FAIL clr_ctrl: got %h expected %h", v, 32'h1); else pass_cnt++;
        @(negedge clk);
        rd(32'h08, v); total_cnt++;
        if (v !== 32'h1) $display("FAIL clr_restart: got %h expected %h", v, 32'h1); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(32'h20, 32'h1234);
        repeat (18) @(negedge clk);
        rd(32'h10, v); total_cnt++;
        if (v !== 32'd5) $display("FAIL mid_ms: got %h expected %h", v, 32'd5); else pass_cnt++;
        rd(32'h20, v); total_cnt++;
        if (v !== 32'h1234) $display("FAIL mid_scr0: got %h expected %h", v, 32'h1234); else pass_cnt++;
        rd(32'h08, v); total_cnt++;
        if (v !== 32'd20) $display("FAIL mid_cyc: got %h expected %h", v, 32'd20); else pass_cnt++;
        #2 rst = 1'b0;
        rd(32'h10, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL arst_ms: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h20, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL arst_scr0: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h24, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL arst_scr1: got %h expected %h", v, 32'h0); else pass_cnt++;
        rd(32'h14, v); total_cnt++;
        if (v !== 32'h1) $display("FAIL arst_ctrl: got %h expected %h", v, 32'h1); else pass_cnt++;
        rd(32'h08, v); total_cnt++;
        if (v !== 32'h0) $display("FAIL arst_cyc: got %h expected %h", v, 32'h0); else pass_cnt++;
        total_cnt++;
        if (iout !== 32'h0) $display("FAIL arst_iout: got %h expected %h", iout, 32'h0); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; ie = 1'b0; de = 1'b0; drw = 2'b00;
        iaddr = 32'h0; daddr = 32'h0; din = 32'h0;
        #2 rst = 1'b0;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        ie = 1'b1; iaddr = 32'hFFFF_FFF0;
        test_ms();
        test_en_freeze();
        test_scratch();
        test_carry();
        test_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mod_sysinfo.md
# mod_sysinfo

Parametrised successor to the board-ID block: a memory-mapped system-information peripheral on the PLP data bus. It reports CPU ID, board frequency and scratch count, and keeps a free-running 64-bit cycle counter with an atomic two-word read. It also keeps a 32-bit millisecond counter derived from the board frequency and provides a bank of read/write scratch registers. The instruction port is tied off. Software uses the block for identification, timing and loader hand-off data.

## Interface
Parameters:
- CPU_ID, 32'h00000302, value returned at offset 0x00
- BOARD_FREQ, 32'h017d7840, board clock in Hz (25 MHz), returned at 0x04
- TICK_DIV, BOARD_FREQ/1000 (25000), clocks per millisecond tick; legal range is 2 or more
- NUM_SCRATCH, 4, number of 32-bit scratch registers; legal range is 1..8

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ie  in  1  instruction-port enable (ignored)
- de  in  1  data-port enable
- iaddr  in  32  instruction address (ignored)
- daddr  in  32  data byte address, relative to the block base
- drw  in  2  bit0 = write strobe, bit1 = read strobe
- din  in  32  write data
- iout  out  32  always 0
- dout  out  32  read data, combinational from daddr; 0 when unmapped

## Operation
Register map (word offsets; daddr[1:0] ignored; any nonzero daddr[31:8] reads 0 and ignores writes):
- 0x00 CPU_ID, read-only (RO)
- 0x04 BOARD_FREQ, RO
- 0x08 CYC_LO, RO. Returns live cycle[31:0]. A read strobe here latches cycle[63:32] into SNAP.
- 0x0C CYC_HI, RO. Returns SNAP, not the live high word.
- 0x10 MS, RO. Millisecond counter.
- 0x14 CTRL. Bit0 EN (read/write, reset 1) enables cycle, prescaler and MS counting. Bit1 CLR is write-1, self-clearing, and always reads 0. Bits 31:2 read 0.
- 0x18 NSCR, RO. Returns NUM_SCRATCH.
- 0x20 + 4*i SCR[i], read/write, for i < NUM_SCRATCH. Offsets at or beyond NUM_SCRATCH read 0.

Write and read rules:
- A write occurs on the clk rising edge when de=1 and drw[0]=1.
- Writes to RO or unmapped offsets are ignored.
- A read strobe counts only when de=1 and drw[1]=1.

Counters:
- The cycle counter is 64-bit and increments by 1 every clk while EN=1. It wraps from 2^64-1 to 0.
- The prescaler counts 0..TICK_DIV-1 while EN=1. On the edge where it is at TICK_DIV-1, it returns to 0 and MS increments. MS wraps from 2^32-1 to 0.
- EN=0 freezes the cycle counter, prescaler and MS. Reads continue to work.

Boundary and precedence rules:
- CLR takes priority over increment and over a snapshot on the same edge. On that edge cycle, prescaler, MS and SNAP become 0. EN is left unchanged unless the same CTRL write changes it.
- A CTRL write of 0x3 both clears the counters and keeps EN=1. The counter reads 1 one clock later.
- A CYC_LO read on the same edge as an increment returns the pre-edge low word and snapshots the pre-edge high word. The pair is therefore consistent across a carry from the low word.
- A CYC_HI read with no prior CYC_LO read returns the last SNAP, or 0 after reset.

## Timing
- Reset (rst=0, asynchronous): cycle=0, prescaler=0, MS=0, SNAP=0, EN=1, all SCR=0. dout then reflects these values, and iout=0.
- Read latency is 0: dout is combinational from daddr and the current registers.
- Write latency is 1 edge: the new value is visible on dout in the next cycle.
- The first MS increment occurs TICK_DIV clocks after reset release.
- Reset asserted mid-count forces all state to the reset values immediately, without waiting for clk.

## Structure
- A shared package/header holds the register offset constants (OFF_CPUID … OFF_SCR0) and the CTRL bit positions.
- One sub-module, mod_sysinfo_tick: the prescaler. Inputs are clk, rst, en and clr; output is a one-cycle tick pulse. It is parametrised by TICK_DIV.
- The top level contains the address decode, the 64-bit counter, SNAP, CTRL, the scratch array and the read mux.

## Test plan
- Reset, then read 0x00, 0x04 and 0x18 → 0x00000302, 0x017d7840, 0x00000004; iout=0 throughout.
- Write 0xDEADBEEF to 0x24, then read 0x24, 0x20 and 0x30 → 0xDEADBEEF, 0, 0. A write to 0x00 leaves its read at 0x00000302.
- Force cycle=0x00000000_FFFFFFFF, read 0x08 on the carry edge, then read 0x0C → 0xFFFFFFFF, then 0x00000000. A fresh 0x08/0x0C pair then reads 0x00000001 (or later), then 0x00000001.
- TICK_DIV=4: MS reads 0 for 3 clocks after reset, reads 1 at the 4th edge, and reads 3 after 12 edges. With EN=0 written, MS stays constant for 20 clocks.
- Write 0x3 to CTRL on the same edge as a 0x08 read → next cycle cycle=0, SNAP=0, MS=0; CTRL reads 0x1.
- Assert rst mid-count (MS=5, SCR0=0x1234) between clock edges → immediately MS=0, SCR0=0, CTRL=0x1.
